seq_divider32: RTL and testbench

- Multi-cycle 32-bit integer divider for the ALU; the subtract-side counterpart of the ripple adder.
- Computes quotient and remainder by restoring division: one trial subtraction per clock, 32 iterations.
- Sits beside the combinational ALU and is started by the ALU control with a Start/Done handshake.
- Supports signed (truncating, C semantics) and unsigned operands.

---
 rtl/alu_pkg.sv | 17 +
 rtl/full_adder.sv | 13 +
 rtl/subtractor_32bit.sv | 30 +++
 rtl/seq_divider32.sv | 151 +++++++++++++++
 tb/tb_seq_divider32.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, divider iteration count, divider state
// encoding and the quotient reported for a zero divisor.
package alu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int DIV_ITER   = 32;

    localparam logic [DATA_WIDTH-1:0] DIV_BY_ZERO_Q = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell shared by the ripple adder and the subtractor.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/subtractor_32bit.sv
// Ripple subtractor a_i - b_i built from full adders (inverted b_i, carry-in 1).
// borrow_o is 1 when a_i < b_i as unsigned numbers.
module subtractor_32bit
    import alu_pkg::*;
#(
    parameter int W = DATA_WIDTH
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    logic [W:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (~b_i[i]),
            .c_i (carry[i]),
            .s_o (diff_o[i]),
            .c_o (carry[i+1])
        );
    end

    assign borrow_o = ~carry[W];

endmodule

// File: rtl/seq_divider32.sv
// Multi-cycle restoring divider: one trial subtraction per clock, signed
// (truncating) or unsigned, with a Start/Done handshake to the ALU control.
module seq_divider32
    import alu_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Rem,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [1:0]       DbgState
);

    localparam int CW = $clog2(ITER);

    // Handshake: Start is taken on any rising edge where the block is in IDLE or
    // DONE, together with Signed/A/B; it is ignored while Busy. Done is a
    // one-cycle pulse in the cycle Q/Rem/DivByZero first show the new result.
    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic             neg_q_q, neg_r_q;
    logic [WIDTH-1:0] q_q, rem_q;
    logic             dbz_q;

    logic             accept;
    logic             b_zero;
    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   trial_diff;
    logic             trial_borrow;
    logic [WIDTH-1:0] neg_x_in, neg_y_in, neg_x, neg_y;
    logic             neg_x_borrow, neg_y_borrow;
    logic             unused_bits;

    assign accept  = Start && ((state_q == IDLE) || (state_q == DONE));
    assign b_zero  = (B == '0);
    assign p_shift = {p_q, dvd_q[WIDTH-1]};

    subtractor_32bit #(.W(WIDTH + 1)) u_trial (
        .a_i      (p_shift),
        .b_i      ({1'b0, dvs_q}),
        .diff_o   (trial_diff),
        .borrow_o (trial_borrow)
    );

    // The two negators take the operand magnitudes at acceptance and the
    // sign-corrected results in FIX; they are never needed in the same cycle.
    assign neg_x_in = (state_q == FIX) ? dvd_q : A;
    assign neg_y_in = (state_q == FIX) ? p_q   : B;

    subtractor_32bit #(.W(WIDTH)) u_neg_x (
        .a_i      ('0),
        .b_i      (neg_x_in),
        .diff_o   (neg_x),
        .borrow_o (neg_x_borrow)
    );

    subtractor_32bit #(.W(WIDTH)) u_neg_y (
        .a_i      ('0),
        .b_i      (neg_y_in),
        .diff_o   (neg_y),
        .borrow_o (neg_y_borrow)
    );

    // The remainder never exceeds the divisor, so the difference MSB is always 0
    // when it is kept.
    assign unused_bits = ^{trial_diff[WIDTH], neg_x_borrow, neg_y_borrow};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (Start) state_d = b_zero ? DONE : RUN;
            end
            RUN: begin
                if (cnt_q == CW'(ITER - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = DONE;
            end
            DONE: begin
                if (Start) state_d = b_zero ? DONE : RUN;
                else       state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy     = (state_q == RUN) || (state_q == FIX);
        Done     = (state_q == DONE);
        DbgState = state_q;
    end

    assign Q         = q_q;
    assign Rem       = rem_q;
    assign DivByZero = dbz_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q   <= '0;
            p_q     <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            q_q     <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else if (accept) begin
            cnt_q   <= '0;
            p_q     <= '0;
            dvd_q   <= (Signed && A[WIDTH-1]) ? neg_x : A;
            dvs_q   <= (Signed && B[WIDTH-1]) ? neg_y : B;
            neg_q_q <= Signed && (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r_q <= Signed && A[WIDTH-1];
            dbz_q   <= b_zero;
            if (b_zero) begin
                q_q   <= DIV_BY_ZERO_Q;
                rem_q <= A;
            end
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q + 1'b1;
            p_q   <= trial_borrow ? p_shift[WIDTH-1:0] : trial_diff[WIDTH-1:0];
            dvd_q <= {dvd_q[WIDTH-2:0], ~trial_borrow};
        end else if (state_q == FIX) begin
            q_q   <= neg_q_q ? neg_x : dvd_q;
            rem_q <= neg_r_q ? neg_y : p_q;
        end
    end

endmodule

// File: tb/tb_seq_divider32.sv
// Bench for seq_divider32: directed literal cases plus randomized traffic, all
// checked every cycle against a plain-arithmetic model of the divider.
module tb_seq_divider32;

    logic        clk = 1'b0;
    logic        rst, start, sgn;
    logic [31:0] a, b;
    logic [31:0] q, rem;
    logic        busy, done, dbz;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    seq_divider32 dut (
        .Clk       (clk),
        .Reset     (rst),
        .Start     (start),
        .Signed    (sgn),
        .A         (a),
        .B         (b),
        .Q         (q),
        .Rem       (rem),
        .Busy      (busy),
        .Done      (done),
        .DivByZero (dbz),
        .DbgState  (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_div(input logic [31:0] x, input logic [31:0] y, input bit s,
                                      output logic [31:0] mq, output logic [31:0] mr,
                                      output bit mz);
        longint lx, ly;
        if (y == 32'd0) begin
            mq = 32'hFFFF_FFFF;
            mr = x;
            mz = 1'b1;
        end else begin
            lx = s ? longint'($signed(x)) : longint'({32'd0, x});
            ly = s ? longint'($signed(y)) : longint'({32'd0, y});
            mq = 32'(lx / ly);
            mr = 32'(lx % ly);
            mz = 1'b0;
        end
    endfunction

    // Scoreboard: results of accepted divisions wait here until their Done cycle.
    logic [31:0] exp_quo[$];
    logic [31:0] exp_rem[$];
    bit          exp_dz[$];

    bit          in_flight = 1'b0;
    int          left = 0;
    bit          exp_done = 1'b0;
    logic [31:0] shown_q = '0;
    logic [31:0] shown_r = '0;
    bit          shown_dz = 1'b0;

    always @(posedge clk) begin
        logic [31:0] mq, mr;
        bit          mz;
        if (rst) begin
            in_flight = 1'b0;
            left      = 0;
            exp_done  = 1'b0;
            shown_q   = '0;
            shown_r   = '0;
            shown_dz  = 1'b0;
            exp_quo.delete();
            exp_rem.delete();
            exp_dz.delete();
        end else begin
            exp_done = 1'b0;
            if (in_flight) begin
                left--;
                if (left == 0) begin
                    in_flight = 1'b0;
                    exp_done  = 1'b1;
                    shown_q   = exp_quo.pop_front();
                    shown_r   = exp_rem.pop_front();
                    shown_dz  = exp_dz.pop_front();
                end
            end else if (start) begin
                model_div(a, b, sgn, mq, mr, mz);
                shown_dz = 1'b0;
                exp_quo.push_back(mq);
                exp_rem.push_back(mr);
                exp_dz.push_back(mz);
                if (mz) begin
                    exp_done = 1'b1;
                    shown_q  = exp_quo.pop_front();
                    shown_r  = exp_rem.pop_front();
                    shown_dz = exp_dz.pop_front();
                end else begin
                    in_flight = 1'b1;
                    left      = 33;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, in_flight);
            check("done", done, exp_done);
            check("q", q, shown_q);
            check("rem", rem, shown_r);
            check("dbz", dbz, shown_dz);
        end
    end

    // Issues one division and waits for its Done; elat = 0 means no Done may appear.
    task automatic do_div(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                          input bit ts, input logic [31:0] eq, input logic [31:0] er,
                          input bit ed, input int elat, input int poke_cyc, input int rst_cyc);
        int cyc;
        bit seen;
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        sgn   = ts;
        @(posedge clk);
        #1 start = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        while (cyc <= 40 && !seen) begin
            if (cyc == poke_cyc) begin
                start = 1'b1;
                a     = 32'd50;
                b     = 32'd5;
            end else if (cyc == poke_cyc + 1) begin
                start = 1'b0;
            end
            if (cyc == rst_cyc) begin
                rst = 1'b1;
            end else if (cyc == rst_cyc + 1) begin
                rst = 1'b0;
                check({tag, " busy after reset"}, busy, 0);
                check({tag, " q after reset"}, q, 0);
                check({tag, " rem after reset"}, rem, 0);
                check({tag, " done after reset"}, done, 0);
            end
            if (elat == 34 && (cyc == 1 || cyc == 33)) check({tag, " busy edge"}, busy, 1);
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1 cyc++;
            end
        end
        if (elat == 0) begin
            check({tag, " unexpected done"}, seen, 0);
        end else begin
            check({tag, " done seen"}, seen, 1);
            if (seen) begin
                check({tag, " latency"}, cyc, elat);
                check({tag, " q"}, q, eq);
                check({tag, " rem"}, rem, er);
                check({tag, " dbz"}, dbz, ed);
            end
        end
    endtask

    function automatic logic [31:0] rand_divisor();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 300));
            4:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] mq, mr;
        bit          mz;

        rst   = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        a     = '0;
        b     = '0;

        model_div(32'hFFFF_FF9C, 32'd7, 1'b1, mq, mr, mz);
        check("model s-100/7 q", mq, 32'hFFFF_FFF2);
        check("model s-100/7 rem", mr, 32'hFFFF_FFFE);
        model_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mq, mr, mz);
        check("model ovf q", mq, 32'h8000_0000);
        check("model ovf rem", mr, 32'd0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset q", q, 0);
        check("reset rem", rem, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset dbz", dbz, 0);
        check("reset state", dbg_state, 0);
        chk_en = 1'b1;

        do_div("u100/7",   32'd100,         32'd7,           1'b0, 32'd14,          32'd2,           1'b0, 34, -5, -5);
        do_div("s-100/7",  32'hFFFF_FF9C,   32'd7,           1'b1, 32'hFFFF_FFF2,   32'hFFFF_FFFE,   1'b0, 34, -5, -5);
        do_div("s100/-7",  32'd100,         32'hFFFF_FFF9,   1'b1, 32'hFFFF_FFF2,   32'd2,           1'b0, 34, -5, -5);
        do_div("u5/0",     32'd5,           32'd0,           1'b0, 32'hFFFF_FFFF,   32'd5,           1'b1, 1,  -5, -5);
        do_div("s5/0",     32'd5,           32'd0,           1'b1, 32'hFFFF_FFFF,   32'd5,           1'b1, 1,  -5, -5);
        do_div("u9/3",     32'd9,           32'd3,           1'b0, 32'd3,           32'd0,           1'b0, 34, -5, -5);
        do_div("s ovf",    32'h8000_0000,   32'hFFFF_FFFF,   1'b1, 32'h8000_0000,   32'd0,           1'b0, 34, -5, -5);
        do_div("umax/1",   32'hFFFF_FFFF,   32'd1,           1'b0, 32'hFFFF_FFFF,   32'd0,           1'b0, 34, -5, -5);
        do_div("poke",     32'd100,         32'd7,           1'b0, 32'd14,          32'd2,           1'b0, 34, 10, -5);
        do_div("b2b50/5",  32'd50,          32'd5,           1'b0, 32'd10,          32'd0,           1'b0, 34, -5, -5);
        do_div("rst mid",  32'd100,         32'd7,           1'b0, 32'd0,           32'd0,           1'b0, 0,  -5, 12);
        do_div("u8/3",     32'd8,           32'd3,           1'b0, 32'd2,           32'd2,           1'b0, 34, -5, -5);

        for (int i = 0; i < 150; i++) begin
            start = 1'b1;
            sgn   = 1'($urandom_range(0, 1));
            a     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
            b     = rand_divisor();
            @(posedge clk);
            #1 start = 1'b0;
            repeat ($urandom_range(0, 40)) begin
                start = ($urandom_range(0, 9) == 0);
                if (start) begin
                    sgn = 1'($urandom_range(0, 1));
                    a   = $urandom;
                    b   = rand_divisor();
                end
                rst = ($urandom_range(0, 299) == 0);
                @(posedge clk);
                #1;
            end
            start = 1'b0;
            rst   = 1'b0;
        end

        repeat (40) @(posedge clk);
        #1 chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
